// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: state encoding, vector
// geometry and the golden truth vector of Y = !A && (B || D).
package truth_table_sweeper_pkg;

   localparam int unsigned VEC_COUNT = 16;
   localparam int unsigned IDX_W     = 4;

   localparam logic [VEC_COUNT-1:0] DEFAULT_EXPECTED = 16'h00FA;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_DRIVE  = 2'd1;
   localparam state_t ST_SAMPLE = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

endpackage : truth_table_sweeper_pkg

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle timer: loads the settle count on entry to DRIVE and flags the
// last DRIVE cycle so the FSM moves to SAMPLE on the following edge.
module truth_table_sweeper_settle_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic       expired
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A count of 1 marks the final DRIVE cycle of the window.
   assign expired = (cnt_q == 4'd1);

endmodule : truth_table_sweeper_settle_timer

// File: rtl/truth_table_sweeper.sv
// Drives A/B/C/D through all 16 vectors, samples Y after the settle time,
// and reports the captured truth vector against the expected constant.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int unsigned          SETTLE   = 1,
   parameter logic [VEC_COUNT-1:0] EXPECTED = DEFAULT_EXPECTED
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 y_in,
   output logic                 a,
   output logic                 b,
   output logic                 c,
   output logic                 d,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [VEC_COUNT-1:0] truth,
   output logic [4:0]           err_count,
   output logic [IDX_W-1:0]     first_err_idx,
   output state_t               state_dbg
);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [VEC_COUNT-1:0]   truth_q, truth_d;
   logic [4:0]             err_q, err_d;
   logic [IDX_W-1:0]       first_q, first_d;
   logic                   pass_q, pass_d;
   logic                   timer_load;
   logic                   timer_expired;

   truth_table_sweeper_settle_timer u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (4'(SETTLE)),
      .expired  (timer_expired)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      truth_d    = truth_q;
      err_d      = err_q;
      first_d    = first_q;
      pass_d     = pass_q;
      timer_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               idx_d   = '0;
               truth_d = '0;
               err_d   = '0;
               first_d = '0;
               pass_d  = 1'b0;
               if (SETTLE == 0) begin
                  state_d = ST_SAMPLE;
               end else begin
                  state_d    = ST_DRIVE;
                  timer_load = 1'b1;
               end
            end
         end
         ST_DRIVE: begin
            if (timer_expired) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            truth_d[idx_q] = y_in;
            // err_q==0 means no mismatch yet in this sweep, so this is the first.
            if (y_in != EXPECTED[idx_q]) begin
               err_d = err_q + 5'd1;
               if (err_q == 5'd0) first_d = idx_q;
            end
            if (idx_q == 4'd15) begin
               state_d = ST_DONE;
               pass_d  = (err_d == 5'd0);
            end else begin
               idx_d = idx_q + 4'd1;
               if (SETTLE == 0) begin
                  state_d = ST_SAMPLE;
               end else begin
                  state_d    = ST_DRIVE;
                  timer_load = 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         truth_q <= '0;
         err_q   <= '0;
         first_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         truth_q <= truth_d;
         err_q   <= err_d;
         first_q <= first_d;
         pass_q  <= pass_d;
      end
   end

   assign busy          = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
   assign done          = (state_q == ST_DONE);
   assign {a, b, c, d}  = busy ? idx_q : 4'b0000;
   assign pass          = pass_q;
   assign truth         = truth_q;
   assign err_count     = err_q;
   assign first_err_idx = first_q;
   assign state_dbg     = state_q;

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table-driven full sweeps at SETTLE=1 plus
// hand-written reset-abort and SETTLE=0 sequences.
module tb_truth_table_sweeper;
   import truth_table_sweeper_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        y_in;
   logic        a, b, c, d;
   logic        busy, done, pass;
   logic [15:0] truth;
   logic [4:0]  err_count;
   logic [3:0]  first_err_idx;
   state_t      state_dbg;

   logic        start0;
   logic        y_in0;
   logic        a0, b0, c0, d0;
   logic        busy0, done0, pass0;
   logic [15:0] truth0;
   logic [4:0]  err_count0;
   logic [3:0]  first_err_idx0;
   state_t      state_dbg0;

   int mode;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic model(input logic [3:0] v);
      return !v[3] && (v[2] || v[0]);
   endfunction

   always_comb begin
      case (mode)
         1:       y_in = 1'b0;
         2:       y_in = ~model({a, b, c, d});
         default: y_in = model({a, b, c, d});
      endcase
      y_in0 = model({a0, b0, c0, d0});
   end

   truth_table_sweeper #(.SETTLE(1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .y_in(y_in),
      .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
      .truth(truth), .err_count(err_count), .first_err_idx(first_err_idx),
      .state_dbg(state_dbg)
   );

   truth_table_sweeper #(.SETTLE(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .y_in(y_in0),
      .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
      .truth(truth0), .err_count(err_count0), .first_err_idx(first_err_idx0),
      .state_dbg(state_dbg0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int          mode;
      logic [15:0] truth;
      logic [4:0]  err;
      logic [3:0]  first;
      logic        pass;
      bit          poke;
   } vec_t;

   vec_t vecs[4];

   // Full sweep on the SETTLE=1 instance; poke re-asserts start at cycles 10 and 33.
   task automatic run_sweep(input vec_t v);
      int n;
      int bad;
      mode  = v.mode;
      start = 1'b1;
      tick();
      start = 1'b0;
      n     = 1;
      bad   = 0;
      while (n < 100) begin
         start = v.poke && (n == 10 || n == 33);
         if (done) break;
         if (!busy || {a, b, c, d} !== 4'((n - 1) / 2)) bad++;
         tick();
         n++;
      end
      check("abcd_sequence", 32'(bad), 32'd0);
      check("done_latency", 32'(n), 32'd33);
      check("busy_at_done", 32'(busy), 32'd0);
      check("abcd_at_done", 32'({a, b, c, d}), 32'd0);
      check("truth", 32'(truth), 32'(v.truth));
      check("err_count", 32'(err_count), 32'(v.err));
      check("first_err_idx", 32'(first_err_idx), 32'(v.first));
      check("pass", 32'(pass), 32'(v.pass));
      tick();
      start = 1'b0;
      check("done_single_pulse", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
      if (v.poke) begin
         for (int k = 0; k < 3; k++) begin
            tick();
            check("no_restart", 32'({busy, done}), 32'd0);
         end
      end
      check("results_hold", 32'(truth), 32'(v.truth));
   endtask

   initial begin
      int n;
      int bad;
      rst    = 1'b1;
      start  = 1'b0;
      start0 = 1'b0;
      mode   = 0;
      vecs[0] = '{0, 16'h00FA, 5'd0,  4'd0, 1'b1, 1'b0};
      vecs[1] = '{1, 16'h0000, 5'd6,  4'd1, 1'b0, 1'b0};
      vecs[2] = '{2, 16'hFF05, 5'd16, 4'd0, 1'b0, 1'b0};
      vecs[3] = '{0, 16'h00FA, 5'd0,  4'd0, 1'b1, 1'b1};
      tick();
      tick();
      rst = 1'b0;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_pass", 32'(pass), 32'd0);
      check("reset_truth", 32'(truth), 32'd0);
      check("reset_err", 32'(err_count), 32'd0);
      check("reset_first", 32'(first_err_idx), 32'd0);
      check("reset_abcd", 32'({a, b, c, d}), 32'd0);
      check("reset_state", 32'(state_dbg), 32'(ST_IDLE));

      for (int i = 0; i < 4; i++) begin
         run_sweep(vecs[i]);
      end

      // Abort mid-sweep with a one-cycle reset at cycle 15.
      mode  = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 15; k++) tick();
      check("pre_abort_truth_nonzero", 32'(truth != 16'h0000), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_abcd", 32'({a, b, c, d}), 32'd0);
      check("abort_truth", 32'(truth), 32'd0);
      check("abort_err", 32'(err_count), 32'd0);
      tick();
      run_sweep(vecs[0]);

      // SETTLE=0 instance: one cycle per vector, done at cycle 17.
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      n   = 1;
      bad = 0;
      while (n < 100 && !done0) begin
         if (!busy0 || {a0, b0, c0, d0} !== 4'(n - 1)) bad++;
         tick();
         n++;
      end
      check("s0_abcd_sequence", 32'(bad), 32'd0);
      check("s0_done_latency", 32'(n), 32'd17);
      check("s0_truth", 32'(truth0), 32'h00FA);
      check("s0_pass", 32'(pass0), 32'd1);
      check("s0_err", 32'(err_count0), 32'd0);
      tick();
      check("s0_done_single_pulse", 32'(done0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_truth_table_sweeper
